// File: rtl/carfield_apb_pkg.sv
// Shared APB types, decoder FSM states and the default Carfield peripheral address map.
package carfield_apb_pkg;

    localparam int unsigned ApbAddrWidth = 32;
    localparam int unsigned ApbDataWidth = 32;
    localparam int unsigned ApbStrbWidth = ApbDataWidth / 8;

    typedef struct packed {
        logic [ApbAddrWidth-1:0] paddr;
        logic [2:0]              pprot;
        logic                    psel;
        logic                    penable;
        logic                    pwrite;
        logic [ApbDataWidth-1:0] pwdata;
        logic [ApbStrbWidth-1:0] pstrb;
    } apb_req_t;

    typedef struct packed {
        logic [ApbDataWidth-1:0] prdata;
        logic                    pready;
        logic                    pslverr;
    } apb_resp_t;

    // end_addr is exclusive; start_addr == end_addr describes an empty rule.
    typedef struct packed {
        logic [31:0]             idx;
        logic [ApbAddrWidth-1:0] start_addr;
        logic [ApbAddrWidth-1:0] end_addr;
    } apb_rule_t;

    typedef enum logic [2:0] {
        ApbDecIdle   = 3'd0,
        ApbDecSetup  = 3'd1,
        ApbDecAccess = 3'd2,
        ApbDecResp   = 3'd3,
        ApbDecErr    = 3'd4
    } apb_dec_state_e;

    localparam int unsigned CarfieldNumApb = 7;

    localparam logic [31:0] CanBase       = 32'h2000_1000;
    localparam logic [31:0] TimerBase     = 32'h2000_4000;
    localparam logic [31:0] AdvTimerBase  = 32'h2000_5000;
    localparam logic [31:0] WatchdogBase  = 32'h2000_7000;
    localparam logic [31:0] HyperBusBase  = 32'h2000_8000;
    localparam logic [31:0] StreamerBase  = 32'h2000_9000;
    localparam logic [31:0] SpaceWireBase = 32'h2001_9000;
    localparam logic [31:0] PeriphSize    = 32'h0000_1000;
    localparam logic [31:0] StreamerSize  = 32'h0000_8000;

    localparam apb_rule_t CarfieldApbMap [CarfieldNumApb] = '{
        '{idx: 32'd0, start_addr: CanBase,       end_addr: CanBase       + PeriphSize},
        '{idx: 32'd1, start_addr: TimerBase,     end_addr: TimerBase     + PeriphSize},
        '{idx: 32'd2, start_addr: AdvTimerBase,  end_addr: AdvTimerBase  + PeriphSize},
        '{idx: 32'd3, start_addr: WatchdogBase,  end_addr: WatchdogBase  + PeriphSize},
        '{idx: 32'd4, start_addr: HyperBusBase,  end_addr: HyperBusBase  + PeriphSize},
        '{idx: 32'd5, start_addr: StreamerBase,  end_addr: StreamerBase  + StreamerSize},
        '{idx: 32'd6, start_addr: SpaceWireBase, end_addr: SpaceWireBase + PeriphSize}
    };

endpackage

// File: rtl/carfield_apb_addr_decode.sv
// Combinational address-rule match; the lowest-numbered matching rule decides the target.
module carfield_apb_addr_decode
    import carfield_apb_pkg::*;
#(
    parameter int unsigned NumSlaves = 7,
    localparam int unsigned IdxWidth = (NumSlaves > 1) ? $clog2(NumSlaves) : 1
) (
    input  logic [ApbAddrWidth-1:0] addr_i,
    input  apb_rule_t               addr_map_i [NumSlaves],
    output logic [IdxWidth-1:0]     idx_o,
    output logic                    hit_o
);

    // Scan from the top so lower rules overwrite higher ones; rules pointing
    // at a non-existent target are treated as if absent.
    always_comb begin
        idx_o = '0;
        hit_o = 1'b0;
        for (int i = NumSlaves - 1; i >= 0; i--) begin
            if ((addr_map_i[i].start_addr <= addr_i) &&
                (addr_i < addr_map_i[i].end_addr) &&
                (addr_map_i[i].idx < NumSlaves)) begin
                idx_o = addr_map_i[i].idx[IdxWidth-1:0];
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/carfield_apb_periph_decoder.sv
// APB 1-to-N address decoder with error responder and access-phase timeout for the
// Carfield peripheral domain.
module carfield_apb_periph_decoder
    import carfield_apb_pkg::*;
#(
    parameter int unsigned NumSlaves     = 7,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  apb_req_t             slv_req_i,
    output apb_resp_t            slv_resp_o,
    output apb_req_t             mst_req_o  [NumSlaves],
    input  apb_resp_t            mst_resp_i [NumSlaves],
    input  apb_rule_t            addr_map_i [NumSlaves],
    input  logic [NumSlaves-1:0] en_mask_i,
    output logic                 timeout_o,
    output logic [AddrWidth-1:0] err_addr_o
);

    localparam int unsigned IdxWidth = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;
    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);

    apb_dec_state_e       state_q, state_d;
    logic [IdxWidth-1:0]  sel_q, sel_d;
    apb_req_t             req_q, req_d;
    logic [DataWidth-1:0] prdata_q, prdata_d;
    logic                 pslverr_q, pslverr_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [AddrWidth-1:0] err_addr_q, err_addr_d;
    logic                 timeout_q, timeout_d;

    logic [IdxWidth-1:0]  dec_idx;
    logic                 dec_hit;

    carfield_apb_addr_decode #(
        .NumSlaves (NumSlaves)
    ) i_addr_decode (
        .addr_i     (slv_req_i.paddr),
        .addr_map_i (addr_map_i),
        .idx_o      (dec_idx),
        .hit_o      (dec_hit)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        req_d      = req_q;
        prdata_d   = prdata_q;
        pslverr_d  = pslverr_q;
        cnt_d      = cnt_q;
        err_addr_d = err_addr_q;
        timeout_d  = 1'b0;
        unique case (state_q)
            ApbDecIdle: begin
                cnt_d = '0;
                if (slv_req_i.psel && !slv_req_i.penable) begin
                    req_d = slv_req_i;
                    sel_d = dec_idx;
                    if (dec_hit && en_mask_i[dec_idx]) begin
                        state_d = ApbDecSetup;
                    end else begin
                        state_d    = ApbDecErr;
                        err_addr_d = slv_req_i.paddr[AddrWidth-1:0];
                    end
                end
            end
            ApbDecSetup: state_d = ApbDecAccess;
            ApbDecAccess: begin
                // A completer ready in the final allowed cycle still wins over the timeout.
                if (mst_resp_i[sel_q].pready) begin
                    prdata_d  = mst_resp_i[sel_q].prdata[DataWidth-1:0];
                    pslverr_d = mst_resp_i[sel_q].pslverr;
                    state_d   = ApbDecResp;
                end else if (cnt_q == CntWidth'(TimeoutCycles - 1)) begin
                    state_d    = ApbDecErr;
                    timeout_d  = 1'b1;
                    err_addr_d = req_q.paddr[AddrWidth-1:0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ApbDecResp, ApbDecErr: begin
                state_d = ApbDecIdle;
                cnt_d   = '0;
            end
            default: state_d = ApbDecIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ApbDecIdle;
            sel_q      <= '0;
            req_q      <= '0;
            prdata_q   <= '0;
            pslverr_q  <= 1'b0;
            cnt_q      <= '0;
            err_addr_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            req_q      <= req_d;
            prdata_q   <= prdata_d;
            pslverr_q  <= pslverr_d;
            cnt_q      <= cnt_d;
            err_addr_q <= err_addr_d;
            timeout_q  <= timeout_d;
        end
    end

    // The upstream response is only presented while the requester still selects us.
    always_comb begin
        slv_resp_o = '0;
        if (state_q == ApbDecResp) begin
            slv_resp_o.pready  = slv_req_i.psel;
            slv_resp_o.prdata  = prdata_q;
            slv_resp_o.pslverr = pslverr_q;
        end else if (state_q == ApbDecErr) begin
            slv_resp_o.pready  = slv_req_i.psel;
            slv_resp_o.pslverr = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NumSlaves; i++) begin
            mst_req_o[i]         = req_q;
            mst_req_o[i].psel    = ((state_q == ApbDecSetup) || (state_q == ApbDecAccess)) &&
                                   (sel_q == IdxWidth'(i));
            mst_req_o[i].penable = (state_q == ApbDecAccess) && (sel_q == IdxWidth'(i));
        end
    end

    assign timeout_o  = timeout_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_carfield_apb_periph_decoder.sv
// Randomized bench for carfield_apb_periph_decoder against a transaction-level schedule model.
module tb_carfield_apb_periph_decoder;
    import carfield_apb_pkg::*;

    localparam int NS = 7;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    apb_req_t     up_req;
    apb_resp_t    up_rsp;
    apb_req_t     dn_req [NS];
    apb_resp_t    dn_rsp [NS];
    apb_rule_t    map    [NS];
    logic [NS-1:0] en;
    logic         to_o;
    logic [31:0]  err_addr;

    carfield_apb_periph_decoder #(
        .NumSlaves     (NS),
        .AddrWidth     (32),
        .DataWidth     (32),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .slv_req_i  (up_req),
        .slv_resp_o (up_rsp),
        .mst_req_o  (dn_req),
        .mst_resp_i (dn_rsp),
        .addr_map_i (map),
        .en_mask_i  (en),
        .timeout_o  (to_o),
        .err_addr_o (err_addr)
    );

    // Per-cycle expectations, written by the driver from the transaction plan.
    logic [NS-1:0] exp_psel, exp_pen;
    logic [31:0]   exp_addr, exp_wdata, exp_prdata, exp_err_addr;
    logic          exp_write, exp_pready, exp_pslverr, exp_timeout;
    bit            chk_en = 0;

    int checks = 0;
    int errors = 0;
    int to_pulses = 0;
    logic [31:0] last_prdata = '0;
    logic        last_pslverr = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Target port a spec-level requester would reach, or -1 for an error response.
    function automatic int model_target(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if (map[i].start_addr <= a && a < map[i].end_addr && map[i].idx < NS)
                return en[map[i].idx] ? int'(map[i].idx) : -1;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int j = 0; j < NS; j++) begin
                check($sformatf("dn_psel[%0d]", j), dn_req[j].psel, exp_psel[j]);
                check($sformatf("dn_penable[%0d]", j), dn_req[j].penable, exp_pen[j]);
                if (exp_psel[j]) begin
                    check($sformatf("dn_paddr[%0d]", j), dn_req[j].paddr, exp_addr);
                    check($sformatf("dn_pwdata[%0d]", j), dn_req[j].pwdata, exp_wdata);
                    check($sformatf("dn_pwrite[%0d]", j), dn_req[j].pwrite, exp_write);
                end
            end
            check("up_pready", up_rsp.pready, exp_pready);
            if (exp_pready) begin
                check("up_prdata", up_rsp.prdata, exp_prdata);
                check("up_pslverr", up_rsp.pslverr, exp_pslverr);
            end
            check("timeout", to_o, exp_timeout);
            check("err_addr", err_addr, exp_err_addr);
        end
        if (up_rsp.pready) begin
            last_prdata  = up_rsp.prdata;
            last_pslverr = up_rsp.pslverr;
        end
        if (to_o) to_pulses++;
    end

    task automatic clear_exp();
        exp_psel = '0; exp_pen = '0; exp_addr = '0; exp_wdata = '0; exp_write = 1'b0;
        exp_pready = 1'b0; exp_prdata = '0; exp_pslverr = 1'b0; exp_timeout = 1'b0;
    endtask

    task automatic randomize_dn();
        for (int j = 0; j < NS; j++) begin
            dn_rsp[j].prdata  = $urandom;
            dn_rsp[j].pready  = 1'($urandom_range(0, 1));
            dn_rsp[j].pslverr = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            up_req = '0;
            up_req.paddr = $urandom;
            randomize_dn();
            clear_exp();
            chk_en = 1;
        end
    endtask

    // One upstream transfer; the target completer answers after w wait cycles.
    // abort_k >= 0 asserts reset during that cycle of the transfer.
    task automatic run_txn(input logic [31:0] addr, input bit wr, input int w,
                           input logic [31:0] rdata, input bit serr, input int abort_k);
        int tgt, last;
        bit to;
        logic [31:0] wdata;
        wdata = $urandom;
        tgt   = model_target(addr);
        to    = (tgt >= 0) && (w >= TO);
        last  = (tgt < 0) ? 1 : (to ? 2 + TO : 3 + w);
        for (int k = 0; k <= last; k++) begin
            @(posedge clk); #1;
            up_req.paddr   = addr;
            up_req.pprot   = 3'b0;
            up_req.psel    = 1'b1;
            up_req.penable = (k > 0);
            up_req.pwrite  = wr;
            up_req.pwdata  = wdata;
            up_req.pstrb   = 4'hf;
            randomize_dn();
            if (tgt >= 0) begin
                dn_rsp[tgt] = '0;
                if (!to && k == 2 + w) begin
                    dn_rsp[tgt].prdata  = rdata;
                    dn_rsp[tgt].pready  = 1'b1;
                    dn_rsp[tgt].pslverr = serr;
                end
            end
            clear_exp();
            if (tgt >= 0 && k >= 1 && k < last) begin
                exp_psel[tgt] = 1'b1;
                exp_pen[tgt]  = (k >= 2);
            end
            exp_addr    = addr;
            exp_wdata   = wdata;
            exp_write   = wr;
            exp_pready  = (k == last);
            exp_prdata  = (k == last && tgt >= 0 && !to) ? rdata : 32'h0;
            exp_pslverr = (tgt < 0 || to) ? 1'b1 : serr;
            exp_timeout = to && (k == last);
            if (k == last && (tgt < 0 || to)) exp_err_addr = addr;
            chk_en = 1;
            if (k == abort_k) begin
                chk_en = 0;
                #2 rst_n = 1'b0;
                #1;
                for (int j = 0; j < NS; j++)
                    check($sformatf("rst_psel[%0d]", j), dn_req[j].psel, 64'd0);
                check("rst_pready", up_rsp.pready, 64'd0);
                clear_exp();
                exp_err_addr = '0;
                up_req = '0;
                chk_en = 1;
                @(posedge clk); @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        int p, r, ri;
        up_req = '0;
        for (int j = 0; j < NS; j++) dn_rsp[j] = '0;
        map = CarfieldApbMap;
        en  = '1;
        clear_exp();
        exp_err_addr = '0;

        #2 rst_n = 1'b0;
        chk_en = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Timer read answered in the first ACCESS cycle.
        check("lit_tgt_timer", model_target(32'h2000_4004), 64'd1);
        run_txn(32'h2000_4004, 1'b0, 0, 32'hCAFE_0001, 1'b0, -1);
        idle(1);
        check("lit_timer_prdata", last_prdata, 32'hCAFE_0001);
        check("lit_timer_pslverr", last_pslverr, 64'd0);

        // Write to a disabled SpaceWire target.
        en[6] = 1'b0;
        run_txn(32'h2001_9010, 1'b1, 0, 32'h0, 1'b0, -1);
        idle(1);
        check("lit_disabled_err_addr", err_addr, 32'h2001_9010);
        check("lit_disabled_pslverr", last_pslverr, 64'd1);
        en = '1;

        // Unmapped gap.
        run_txn(32'h2000_2000, 1'b0, 0, 32'h0, 1'b0, -1);
        idle(1);
        check("lit_gap_prdata", last_prdata, 64'd0);
        check("lit_gap_pslverr", last_pslverr, 64'd1);

        // Completer never readies.
        p = to_pulses;
        run_txn(32'h2000_5008, 1'b0, 1000, 32'h0, 1'b0, -1);
        idle(1);
        check("lit_timeout_pulses", 64'(to_pulses - p), 64'd1);
        check("lit_timeout_err_addr", err_addr, 32'h2000_5008);

        // Ready on the last allowed ACCESS cycle beats the timeout.
        run_txn(32'h2000_7004, 1'b0, TO - 1, 32'h5A5A_0003, 1'b1, -1);
        idle(1);
        check("lit_late_ready_prdata", last_prdata, 32'h5A5A_0003);

        // Overlapping rules 0 and 3.
        map[0] = '{idx: 32'd0, start_addr: 32'h2000_0000, end_addr: 32'h2000_8000};
        check("lit_overlap_tgt", model_target(32'h2000_7000), 64'd0);
        run_txn(32'h2000_7000, 1'b0, 1, 32'h0000_7777, 1'b0, -1);
        idle(1);
        map = CarfieldApbMap;

        // Empty rule never matches; end_addr is exclusive.
        map[5].end_addr = map[5].start_addr;
        check("lit_empty_rule_tgt", model_target(32'h2000_9000), -64'sd1);
        run_txn(32'h2000_9000, 1'b0, 0, 32'h0, 1'b0, -1);
        map = CarfieldApbMap;
        run_txn(32'h2000_5000, 1'b1, 0, 32'h0000_2222, 1'b0, -1);
        run_txn(32'h2000_0FFF, 1'b0, 0, 32'h0, 1'b0, -1);

        // Reset during ACCESS, then a normal CAN read.
        run_txn(32'h2000_4010, 1'b0, 1000, 32'h0, 1'b0, 3);
        idle(1);
        run_txn(32'h2000_1000, 1'b0, 0, 32'h1234_5678, 1'b0, -1);
        idle(1);
        check("lit_post_reset_prdata", last_prdata, 32'h1234_5678);
        check("lit_post_reset_err_addr", err_addr, 64'd0);

        for (int n = 0; n < 120; n++) begin
            r  = $urandom_range(0, 3);
            ri = $urandom_range(0, NS - 1);
            case (r)
                0: a = map[ri].start_addr + $urandom_range(0, map[ri].end_addr - map[ri].start_addr - 1);
                1: a = ($urandom_range(0, 1) != 0) ? map[ri].end_addr : map[ri].start_addr - 1;
                2: a = $urandom_range(32'h2000_0000, 32'h2002_1000);
                default: a = $urandom;
            endcase
            en = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '1;
            run_txn(a, 1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom,
                    1'($urandom_range(0, 1)), -1);
            idle($urandom_range(0, 2));
        end
        idle(2);
        chk_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/carfield_apb_periph_decoder.md
# carfield_apb_periph_decoder

APB responder-side address decoder and error responder for the Carfield peripheral domain. It accepts one upstream APB requester, which is the AXI-to-APB bridge of the peripheral region at 0x2000_1000. It routes each transfer to one of `NumSlaves` downstream APB completers using the peripheral address map: CAN, system timer, advanced timer, watchdog, HyperBus config, streamer, SpaceWire. Transfers to unmapped or disabled targets, and transfers whose completer hangs, are completed with `PSLVERR`, so the system bus never stalls.

## Interface
Parameters:
- `NumSlaves`, 7: number of downstream completers and address rules.
- `AddrWidth`, 32: PADDR width.
- `DataWidth`, 32: PWDATA/PRDATA width.
- `TimeoutCycles`, 255: maximum ACCESS-phase wait before forced error; must be ≥ 1.

Ports (clock and reset first):
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `slv_req_i`  in  `apb_req_t`  upstream request: paddr, pprot, psel, penable, pwrite, pwdata, pstrb.
- `slv_resp_o`  out  `apb_resp_t`  upstream response: prdata, pready, pslverr.
- `mst_req_o`  out  `apb_req_t [NumSlaves]`  downstream requests.
- `mst_resp_i`  in  `apb_resp_t [NumSlaves]`  downstream responses.
- `addr_map_i`  in  `apb_rule_t [NumSlaves]`  rules {idx, start_addr, end_addr}; `end_addr` is exclusive.
- `en_mask_i`  in  `NumSlaves`  per-target enable, driven from the CanEnable/StreamerEnable/SpaceWireEnable straps.
- `timeout_o`  out  1  one-cycle pulse on each timeout.
- `err_addr_o`  out  `AddrWidth`  PADDR of the most recent errored transfer.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP, ERR.
- IDLE: on `psel & !penable`, decode PADDR, capture the request and latch `sel_q`.
  - Hit with `en_mask_i[sel]=1` goes to SETUP.
  - Miss, or hit on a disabled target, goes to ERR.
- Decode rules:
  - A rule matches when `start_addr ≤ paddr < end_addr`.
  - A rule with `start_addr == end_addr` never matches.
  - When rules overlap, the lowest rule index wins.
- SETUP: `mst_req_o[sel_q]` drives psel=1, penable=0 with the captured fields. Next state is ACCESS.
- ACCESS:
  - `mst_req_o[sel_q]` drives psel=1, penable=1.
  - On `mst_resp_i[sel_q].pready`, capture prdata/pslverr and go to RESP.
  - When the counter reaches `TimeoutCycles` without pready, go to ERR and pulse `timeout_o`.
- RESP: upstream pready=1 with the captured prdata/pslverr for exactly one cycle, then IDLE.
- ERR: upstream pready=1, pslverr=1, prdata=0 for one cycle; `err_addr_o` updated. Next state is IDLE.
- Non-selected downstream ports always drive psel=0 and penable=0. Their pwdata/paddr may mirror the captured values.
- Upstream `psel` deasserting mid-transfer is a protocol violation: the transfer still completes and the response is dropped.
- The write/read distinction is transparent; the block never inspects pwdata.

## Timing
- Reset values: all outputs 0; FSM=IDLE; timeout counter=0; `err_addr_o`=0.
- Reset asserted mid-transfer:
  - All downstream psel drop immediately, asynchronously.
  - No response is issued upstream.
- Hit latency, upstream setup at cycle T0, completer ready on its first ACCESS cycle:
  - SETUP at T1, ACCESS at T2, RESP at T3.
  - Upstream pready is high at T3; total 4 upstream cycles including setup.
  - Each extra completer wait cycle adds one cycle.
- Miss latency: ERR at T1, so upstream pready is high at T1.
- Timeout:
  - The counter increments every ACCESS cycle with pready=0.
  - At count = `TimeoutCycles`, the FSM enters ERR on the next edge and downstream psel drops that same edge.
  - A pready arriving on the same cycle the count reaches the limit wins: RESP, no timeout.
- The timeout counter clears on every IDLE entry.
- Back-to-back transfers: a new upstream setup is accepted in IDLE the cycle after RESP or ERR, because APB mandates an idle or setup phase.
- Upstream pready is never asserted outside RESP or ERR.

## Structure
- Shared package `carfield_apb_pkg`:
  - `apb_req_t`, `apb_resp_t`, `apb_rule_t`.
  - FSM enum `apb_dec_state_e`.
  - Default rule constants built from the Carfield peripheral map: Can 0x2000_1000, Timer 0x2000_4000, AdvTimer 0x2000_5000, Watchdog 0x2000_7000, HyperBus 0x2000_8000, Streamer 0x2000_9000 (size 0x8000), SpaceWire 0x2001_9000.
- One sub-module: `carfield_apb_addr_decode`, a combinational rule match that outputs `idx` and `hit` and implements lowest-index priority.

## Test plan
- Read 0x2000_4004 (timer), completer pready on the first ACCESS cycle with prdata=0xCAFE_0001 -> only `mst_req_o[1]` selected; upstream pready at T3 with prdata 0xCAFE_0001, pslverr=0.
- Write 0x2001_9010 with `en_mask_i[6]=0` -> no downstream psel; upstream pready at T1, pslverr=1; `err_addr_o`=0x2001_9010.
- Read 0x2000_2000 (unmapped gap) -> ERR at T1, prdata=0, pslverr=1.
- Completer never readies, `TimeoutCycles`=4 -> downstream psel drops after 4 ACCESS cycles; `timeout_o` pulses once; upstream pslverr=1.
- Overlapping rules 0 and 3 both cover 0x2000_7000 -> rule 0's target selected.
- Reset asserted during ACCESS -> all psel=0 immediately; after release, a read to 0x2000_1000 completes normally.
